echo_request_arbiter: RTL

//  Shares the single Echo request$say / indication$heard channel among NUM_REQ requesters.

---
 rtl/echo_request_arbiter_if.sv | 54 +++++
 rtl/echo_request_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/echo_request_arbiter_if.sv
// Bundles the requester-side, Echo-side and response-side handshake signals
// of echo_request_arbiter. The arbiter uses the slave modport; whatever sits
// on the other ends (requesters, Echo, response sinks) uses master.
interface echo_request_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned DATA_W = 32;

  // requester say channel, one lane per requester
  logic [NUM_REQ-1:0]        req_say_ena;
  logic [NUM_REQ-1:0]        req_say_rdy;
  logic [DATA_W*NUM_REQ-1:0] req_say_meth;
  logic [DATA_W*NUM_REQ-1:0] req_say_v;

  // Echo request port
  logic                      echo_say_ena;
  logic [DATA_W-1:0]         echo_say_meth;
  logic [DATA_W-1:0]         echo_say_v;
  logic                      echo_say_rdy;

  // Echo indication port
  logic                      echo_heard_ena;
  logic [DATA_W-1:0]         echo_heard_meth;
  logic [DATA_W-1:0]         echo_heard_v;
  logic                      echo_heard_rdy;

  // response delivery back to the requesters, data shared by all lanes
  logic [NUM_REQ-1:0]        rsp_heard_ena;
  logic [DATA_W-1:0]         rsp_heard_meth;
  logic [DATA_W-1:0]         rsp_heard_v;
  logic [NUM_REQ-1:0]        rsp_heard_rdy;

  modport slave (
    input  req_say_ena, req_say_meth, req_say_v,
    output req_say_rdy,
    output echo_say_ena, echo_say_meth, echo_say_v,
    input  echo_say_rdy,
    input  echo_heard_ena, echo_heard_meth, echo_heard_v,
    output echo_heard_rdy,
    output rsp_heard_ena, rsp_heard_meth, rsp_heard_v,
    input  rsp_heard_rdy
  );

  modport master (
    output req_say_ena, req_say_meth, req_say_v,
    input  req_say_rdy,
    input  echo_say_ena, echo_say_meth, echo_say_v,
    output echo_say_rdy,
    output echo_heard_ena, echo_heard_meth, echo_heard_v,
    input  echo_heard_rdy,
    input  rsp_heard_ena, rsp_heard_meth, rsp_heard_v,
    output rsp_heard_rdy
  );
endinterface

// File: rtl/echo_request_arbiter.sv
// Shares the single Echo say/heard channel among NUM_REQ requesters.
// One transaction at a time: say issue -> heard response -> delivery to the
// issuing requester. A round-robin token picks the next requester; the
// response is steered back by the stored owner index.
module echo_request_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ),
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  echo_request_arbiter_if.slave     bus,
  output logic [IDX_W-1:0]          owner,
  output logic                      busy,
  output logic [CNT_W-1:0]          txn_count,
  output logic                      proto_err
);

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] DELIVER = 2'd3;

  logic [1:0]         state_q,     state_d;
  logic [IDX_W-1:0]   tok_q,       tok_d;
  logic [IDX_W-1:0]   owner_q,     owner_d;
  logic [DATA_W-1:0]  say_meth_q,  say_meth_d;
  logic [DATA_W-1:0]  say_v_q,     say_v_d;
  logic [DATA_W-1:0]  rsp_meth_q,  rsp_meth_d;
  logic [DATA_W-1:0]  rsp_v_q,     rsp_v_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               perr_q,      perr_d;

  logic [NUM_REQ-1:0] tok_onehot_c;
  logic [NUM_REQ-1:0] owner_onehot_c;
  logic               sel_ena_c;
  logic [DATA_W-1:0]  sel_meth_c;
  logic [DATA_W-1:0]  sel_v_c;

  logic [NUM_REQ-1:0] req_rdy_c;
  logic               say_ena_c;
  logic               heard_rdy_c;
  logic [NUM_REQ-1:0] rsp_ena_c;
  logic               req_xfer_c;
  logic               heard_xfer_c;
  logic               rsp_xfer_c;
  logic               perr_hit_c;

  // Index successor, wrapping at NUM_REQ-1 (NUM_REQ need not be a power of two)
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return idx + IDX_W'(1);
  endfunction

  // Decode token/owner to one-hot and mux out the token holder's say lane
  always_comb begin
    tok_onehot_c   = '0;
    owner_onehot_c = '0;
    sel_meth_c     = '0;
    sel_v_c        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tok_onehot_c[i]   = (tok_q == IDX_W'(i));
      owner_onehot_c[i] = (owner_q == IDX_W'(i));
      if (tok_q == IDX_W'(i)) begin
        sel_meth_c = bus.req_say_meth[i*DATA_W +: DATA_W];
        sel_v_c    = bus.req_say_v[i*DATA_W +: DATA_W];
      end
    end
    sel_ena_c = |(bus.req_say_ena & tok_onehot_c);
  end

  // Handshake strobes: RDY from state only, ENA outputs gated by partner RDY
  always_comb begin
    req_rdy_c    = (state_q == IDLE) ? tok_onehot_c : '0;
    say_ena_c    = (state_q == ISSUE) && bus.echo_say_rdy;
    heard_rdy_c  = (state_q == WAIT);
    rsp_ena_c    = (state_q == DELIVER) ? (owner_onehot_c & bus.rsp_heard_rdy) : '0;
    req_xfer_c   = (state_q == IDLE) && sel_ena_c;
    heard_xfer_c = heard_rdy_c && bus.echo_heard_ena;
    rsp_xfer_c   = |rsp_ena_c;
    // any incoming strobe that finds its RDY low is a protocol violation
    perr_hit_c   = (|(bus.req_say_ena & ~req_rdy_c)) ||
                   (bus.echo_heard_ena && !heard_rdy_c);
  end

  // Next-state and datapath update for one transaction at a time
  always_comb begin
    state_d    = state_q;
    tok_d      = tok_q;
    owner_d    = owner_q;
    say_meth_d = say_meth_q;
    say_v_d    = say_v_q;
    rsp_meth_d = rsp_meth_q;
    rsp_v_d    = rsp_v_q;
    cnt_d      = cnt_q;
    perr_d     = perr_q || perr_hit_c;

    case (state_q)
      IDLE: begin
        if (req_xfer_c) begin
          say_meth_d = sel_meth_c;
          say_v_d    = sel_v_c;
          owner_d    = tok_q;
          state_d    = ISSUE;
        end else begin
          tok_d = next_idx(tok_q);
        end
      end
      ISSUE: begin
        if (say_ena_c) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (heard_xfer_c) begin
          rsp_meth_d = bus.echo_heard_meth;
          rsp_v_d    = bus.echo_heard_v;
          state_d    = DELIVER;
        end
      end
      DELIVER: begin
        if (rsp_xfer_c) begin
          cnt_d   = cnt_q + CNT_W'(1);
          tok_d   = next_idx(owner_q);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight transaction
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      tok_q      <= '0;
      owner_q    <= '0;
      say_meth_q <= '0;
      say_v_q    <= '0;
      rsp_meth_q <= '0;
      rsp_v_q    <= '0;
      cnt_q      <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tok_q      <= tok_d;
      owner_q    <= owner_d;
      say_meth_q <= say_meth_d;
      say_v_q    <= say_v_d;
      rsp_meth_q <= rsp_meth_d;
      rsp_v_q    <= rsp_v_d;
      cnt_q      <= cnt_d;
      perr_q     <= perr_d;
    end
  end

  assign bus.req_say_rdy    = req_rdy_c;
  assign bus.echo_say_ena   = say_ena_c;
  assign bus.echo_say_meth  = say_meth_q;
  assign bus.echo_say_v     = say_v_q;
  assign bus.echo_heard_rdy = heard_rdy_c;
  assign bus.rsp_heard_ena  = rsp_ena_c;
  assign bus.rsp_heard_meth = rsp_meth_q;
  assign bus.rsp_heard_v    = rsp_v_q;

  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign txn_count = cnt_q;
  assign proto_err = perr_q;

endmodule
